// File: rtl/mem_access_pkg.sv
// Shared types and op encodings for the MEM-stage load/store unit.
// Big-endian lane rules live in mem_lane_fmt; the bus FSM lives in mem_access.
package mem_access_pkg;

    localparam int ALU_OP_W = 8;
    localparam int REG_W    = 32;
    localparam int RA_W     = 5;
    localparam int SEL_W    = 4;

    localparam logic [RA_W-1:0] NOP_REG_ADDR = '0;

    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_REQ  = 2'b01,
        MEM_DONE = 2'b10
    } mem_state_e;

    function automatic logic is_load_op(input logic [ALU_OP_W-1:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LBU_OP) ||
               (op == EXE_LH_OP)  || (op == EXE_LHU_OP) ||
               (op == EXE_LW_OP);
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational big-endian lane steering: byte enables, store replication,
// load lane extraction with sign/zero extension, and alignment check.
module mem_lane_fmt
    import mem_access_pkg::*;
(
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [1:0]          i_addr,
    input  logic [REG_W-1:0]    i_reg2,
    input  logic [REG_W-1:0]    i_rdata,
    output logic [SEL_W-1:0]    o_sel,
    output logic [REG_W-1:0]    o_wdata,
    output logic [REG_W-1:0]    o_load,
    output logic                o_is_mem,
    output logic                o_is_load,
    output logic                o_we,
    output logic                o_misalign
);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [SEL_W-1:0] w_bsel;
    logic [SEL_W-1:0] w_hsel;

    // Lane 0 (addr 00) is the most significant byte of the bus word.
    assign w_byte = i_addr[1]
                  ? (i_addr[0] ? i_rdata[7:0]   : i_rdata[15:8])
                  : (i_addr[0] ? i_rdata[23:16] : i_rdata[31:24]);
    assign w_half = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];
    assign w_bsel = 4'b1000 >> i_addr;
    assign w_hsel = i_addr[1] ? 4'b0011 : 4'b1100;

    always_comb begin
        o_sel      = '0;
        o_wdata    = i_reg2;
        o_load     = '0;
        o_is_mem   = 1'b0;
        o_we       = 1'b0;
        o_misalign = 1'b0;
        o_is_load  = is_load_op(i_op);
        unique case (i_op)
            EXE_LB_OP: begin
                o_is_mem = 1'b1;
                o_sel    = w_bsel;
                o_load   = {{24{w_byte[7]}}, w_byte};
            end
            EXE_LBU_OP: begin
                o_is_mem = 1'b1;
                o_sel    = w_bsel;
                o_load   = {24'b0, w_byte};
            end
            EXE_LH_OP: begin
                o_is_mem   = 1'b1;
                o_misalign = i_addr[0];
                o_sel      = w_hsel;
                o_load     = {{16{w_half[15]}}, w_half};
            end
            EXE_LHU_OP: begin
                o_is_mem   = 1'b1;
                o_misalign = i_addr[0];
                o_sel      = w_hsel;
                o_load     = {16'b0, w_half};
            end
            EXE_LW_OP: begin
                o_is_mem   = 1'b1;
                o_misalign = |i_addr;
                o_sel      = 4'b1111;
                o_load     = i_rdata;
            end
            EXE_SB_OP: begin
                o_is_mem = 1'b1;
                o_we     = 1'b1;
                o_sel    = w_bsel;
                o_wdata  = {4{i_reg2[7:0]}};
            end
            EXE_SH_OP: begin
                o_is_mem   = 1'b1;
                o_we       = 1'b1;
                o_misalign = i_addr[0];
                o_sel      = w_hsel;
                o_wdata    = {2{i_reg2[15:0]}};
            end
            EXE_SW_OP: begin
                o_is_mem   = 1'b1;
                o_we       = 1'b1;
                o_misalign = |i_addr;
                o_sel      = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs a req/ack bus transaction for loads and stores, stalling
// the pipeline until it completes; non-memory results pass straight through.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] aluOp_i,
    input  logic [REG_W-1:0]    mem_addr_i,
    input  logic [REG_W-1:0]    reg2_i,
    input  logic [RA_W-1:0]     wd_i,
    input  logic                wreg_i,
    input  logic [REG_W-1:0]    wdata_i,
    output logic [RA_W-1:0]     wd_o,
    output logic                wreg_o,
    output logic [REG_W-1:0]    wdata_o,
    output logic                stallreq_o,
    output logic                align_err_o,
    output logic                bus_err_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [REG_W-1:0]    bus_addr_o,
    output logic [SEL_W-1:0]    bus_sel_o,
    output logic [REG_W-1:0]    bus_wdata_o,
    input  logic [REG_W-1:0]    bus_rdata_i,
    input  logic                bus_ack_i
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    mem_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [REG_W-1:0] r_result;
    logic             r_tmo;

    logic [SEL_W-1:0] w_sel;
    logic [REG_W-1:0] w_wdata;
    logic [REG_W-1:0] w_load;
    logic             w_is_mem;
    logic             w_is_load;
    logic             w_we;
    logic             w_misalign;
    logic             w_cnt_last;

    mem_lane_fmt u_fmt (
        .i_op       (aluOp_i),
        .i_addr     (mem_addr_i[1:0]),
        .i_reg2     (reg2_i),
        .i_rdata    (bus_rdata_i),
        .o_sel      (w_sel),
        .o_wdata    (w_wdata),
        .o_load     (w_load),
        .o_is_mem   (w_is_mem),
        .o_is_load  (w_is_load),
        .o_we       (w_we),
        .o_misalign (w_misalign)
    );

    assign w_cnt_last = (ACK_TIMEOUT != 0) &&
                        (32'(r_cnt) == 32'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MEM_IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_tmo       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
        end else begin
            unique case (r_state)
                MEM_IDLE: begin
                    r_tmo <= 1'b0;
                    if (w_is_mem && !w_misalign) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= w_we;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o   <= w_sel;
                        bus_wdata_o <= w_wdata;
                        r_cnt       <= '0;
                        r_state     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    // An ack in the final wait cycle still completes normally.
                    if (bus_ack_i) begin
                        r_result  <= w_load;
                        bus_req_o <= 1'b0;
                        r_state   <= MEM_DONE;
                    end else if (w_cnt_last) begin
                        r_tmo     <= 1'b1;
                        bus_req_o <= 1'b0;
                        r_state   <= MEM_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                MEM_DONE: begin
                    r_state <= MEM_IDLE;
                end
                default: begin
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        align_err_o = 1'b0;
        bus_err_o   = 1'b0;
        if (rst) begin
            wd_o    = NOP_REG_ADDR;
            wreg_o  = 1'b0;
            wdata_o = '0;
        end else begin
            unique case (r_state)
                MEM_IDLE: begin
                    if (w_is_mem) begin
                        if (w_misalign) begin
                            align_err_o = 1'b1;
                            wreg_o      = 1'b0;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                MEM_REQ: begin
                    stallreq_o = 1'b1;
                end
                MEM_DONE: begin
                    if (r_tmo) begin
                        wreg_o    = 1'b0;
                        bus_err_o = 1'b1;
                    end else if (w_is_load) begin
                        wdata_o = r_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a scoreboard of MEM/WB results and a
// simple bus slave that acks after a programmed number of wait cycles.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [ALU_OP_W-1:0] EXE_OR_OP = 8'b0010_0101;

    logic                clk = 1'b0;
    logic                rst;
    logic [ALU_OP_W-1:0] aluOp_i;
    logic [REG_W-1:0]    mem_addr_i;
    logic [REG_W-1:0]    reg2_i;
    logic [RA_W-1:0]     wd_i;
    logic                wreg_i;
    logic [REG_W-1:0]    wdata_i;
    logic [RA_W-1:0]     wd_o;
    logic                wreg_o;
    logic [REG_W-1:0]    wdata_o;
    logic                stallreq_o;
    logic                align_err_o;
    logic                bus_err_o;
    logic                bus_req_o;
    logic                bus_we_o;
    logic [REG_W-1:0]    bus_addr_o;
    logic [SEL_W-1:0]    bus_sel_o;
    logic [REG_W-1:0]    bus_wdata_o;
    logic [REG_W-1:0]    bus_rdata_i;
    logic                bus_ack_i;

    typedef struct {
        logic [RA_W-1:0]  wd;
        logic             wreg;
        logic [REG_W-1:0] wdata;
        logic             berr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluOp_i     (aluOp_i),
        .mem_addr_i  (mem_addr_i),
        .reg2_i      (reg2_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o),
        .align_err_o (align_err_o),
        .bus_err_o   (bus_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat);
        aluOp_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wreg_i     = wr;
        wdata_i    = wdat;
    endtask

    task automatic push(input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat, input logic berr);
        exp_t e;
        e.wd    = wd;
        e.wreg  = wr;
        e.wdata = wdat;
        e.berr  = berr;
        sb.push_back(e);
    endtask

    // Inputs must already be driven; ack arrives in REQ cycle ack_after+1.
    task automatic run_mem(input string tag, input logic [31:0] addr,
                           input logic [31:0] rdata, input int ack_after,
                           input logic [3:0] esel, input logic ewe,
                           input logic [31:0] ebw, input int estall,
                           input int ereq);
        int   stalls = 0;
        int   reqs   = 0;
        bit   done   = 0;
        exp_t e;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (bus_req_o) begin
                reqs++;
                if (reqs == 1) begin
                    chk({tag, ".sel"}, 32'(bus_sel_o), 32'(esel));
                    chk({tag, ".we"}, 32'(bus_we_o), 32'(ewe));
                    chk({tag, ".addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
                    if (ewe) chk({tag, ".bwdata"}, bus_wdata_o, ebw);
                end
            end else if (stalls > 0 && !stallreq_o) begin
                done = 1;
                chk({tag, ".sb"}, 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, ".wd"}, 32'(wd_o), 32'(e.wd));
                    chk({tag, ".wreg"}, 32'(wreg_o), 32'(e.wreg));
                    chk({tag, ".berr"}, 32'(bus_err_o), 32'(e.berr));
                    if (!e.berr) chk({tag, ".wdata"}, wdata_o, e.wdata);
                end
            end
            bus_ack_i   = bus_req_o && (reqs == ack_after + 1);
            bus_rdata_i = rdata;
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".stalls"}, 32'(stalls), 32'(estall));
        chk({tag, ".reqs"}, 32'(reqs), 32'(ereq));
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        drive(EXE_OR_OP, 0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        drive(EXE_OR_OP, 0, 0, 5'd5, 1'b1, 32'h1234);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.wd", 32'(wd_o), 32'd0);
        chk("rst.wreg", 32'(wreg_o), 32'd0);
        chk("rst.wdata", wdata_o, 32'd0);
        chk("rst.stall", 32'(stallreq_o), 32'd0);
        chk("rst.req", 32'(bus_req_o), 32'd0);
        chk("rst.sel", 32'(bus_sel_o), 32'd0);
        chk("rst.baddr", bus_addr_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive(EXE_OR_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        @(negedge clk);
        chk("pt.wd", 32'(wd_o), 32'd5);
        chk("pt.wreg", 32'(wreg_o), 32'd1);
        chk("pt.wdata", wdata_o, 32'h1234);
        chk("pt.stall", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pt.req", 32'(bus_req_o), 32'd0);
        @(posedge clk);
        #1;

        drive(EXE_LB_OP, 32'h103, 0, 5'd7, 1'b1, 32'h0);
        push(5'd7, 1'b1, 32'hFFFF_FFF0, 1'b0);
        run_mem("lb", 32'h103, 32'h0000_00F0, 0, 4'b0001, 1'b0, 0, 2, 1);

        drive(EXE_LBU_OP, 32'h103, 0, 5'd8, 1'b1, 32'h0);
        push(5'd8, 1'b1, 32'h0000_00F0, 1'b0);
        run_mem("lbu", 32'h103, 32'h0000_00F0, 0, 4'b0001, 1'b0, 0, 2, 1);

        drive(EXE_SH_OP, 32'h202, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h55);
        push(5'd0, 1'b0, 32'h55, 1'b0);
        run_mem("sh", 32'h202, 0, 3, 4'b0011, 1'b1, 32'hCCDD_CCDD, 5, 4);

        drive(EXE_LW_OP, 32'h301, 0, 5'd9, 1'b1, 32'h0);
        @(negedge clk);
        chk("mis.align", 32'(align_err_o), 32'd1);
        chk("mis.wreg", 32'(wreg_o), 32'd0);
        chk("mis.stall", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        drive(EXE_OR_OP, 0, 0, 0, 1'b0, 0);
        @(negedge clk);
        chk("mis.req", 32'(bus_req_o), 32'd0);
        chk("mis.align2", 32'(align_err_o), 32'd0);
        @(posedge clk);
        #1;

        drive(EXE_LW_OP, 32'h300, 0, 5'd10, 1'b1, 32'h0);
        push(5'd10, 1'b0, 32'h0, 1'b1);
        run_mem("tmo", 32'h300, 0, -1, 4'b1111, 1'b0, 0, 5, 4);

        drive(EXE_LH_OP, 32'h100, 0, 5'd11, 1'b1, 32'h0);
        push(5'd11, 1'b1, 32'hFFFF_8001, 1'b0);
        run_mem("lh", 32'h100, 32'h8001_1234, 1, 4'b1100, 1'b0, 0, 3, 2);

        drive(EXE_LHU_OP, 32'h102, 0, 5'd12, 1'b1, 32'h0);
        push(5'd12, 1'b1, 32'h0000_8001, 1'b0);
        run_mem("lhu", 32'h102, 32'h1234_8001, 0, 4'b0011, 1'b0, 0, 2, 1);

        drive(EXE_SB_OP, 32'h101, 32'h1234_565A, 5'd0, 1'b0, 32'h66);
        push(5'd0, 1'b0, 32'h66, 1'b0);
        run_mem("sb", 32'h101, 0, 0, 4'b0100, 1'b1, 32'h5A5A_5A5A, 2, 1);

        drive(EXE_SW_OP, 32'h10C, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h77);
        push(5'd0, 1'b0, 32'h77, 1'b0);
        run_mem("sw", 32'h10C, 0, 1, 4'b1111, 1'b1, 32'hDEAD_BEEF, 3, 2);

        drive(EXE_LW_OP, 32'h200, 0, 5'd13, 1'b1, 32'h0);
        push(5'd13, 1'b1, 32'hCAFE_F00D, 1'b0);
        run_mem("lw", 32'h200, 32'hCAFE_F00D, 2, 4'b1111, 1'b0, 0, 4, 3);

        drive(EXE_LW_OP, 32'h400, 0, 5'd14, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rreq.req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rreq.req0", 32'(bus_req_o), 32'd0);
        chk("rreq.stall", 32'(stallreq_o), 32'd0);
        chk("rreq.wreg", 32'(wreg_o), 32'd0);
        rst       = 1'b0;
        bus_ack_i = 1'b1;
        drive(EXE_OR_OP, 0, 0, 5'd3, 1'b1, 32'hBEEF);
        @(posedge clk);
        #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        chk("late.req", 32'(bus_req_o), 32'd0);
        chk("late.stall", 32'(stallreq_o), 32'd0);
        chk("late.wdata", wdata_o, 32'hBEEF);
        chk("late.berr", 32'(bus_err_o), 32'd0);
        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
